// File: rtl/vga_timing_gen_param.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_param
//  Purpose  : Parametrised VGA raster timing generator and pixel-output stage.
//             Produces H/V sync, active-video flag, pixel coordinates,
//             frame/line start pulses and an early fetch request for a
//             pipelined pixel source. Includes a test-pattern generator
//             (colour bars, checkerboard, solid white) whose mode changes
//             only on frame boundaries.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    iCLK         in   pixel clock
//    iRST_N       in   asynchronous active-low reset
//    iEN          in   timing enable; low holds the generator idle at (0,0)
//    iPattern     in   0 pass-through, 1 bars, 2 checkerboard, 3 white
//    iRed/Green/Blue in host pixel colour, valid REQ_LEAD clocks after oRequest
//    oRequest     out  pixel fetch request to the host
//    oVGA_R/G/B   out  colour to DAC, zero outside active video
//    oVGA_H_SYNC  out  horizontal sync (active level H_POL)
//    oVGA_V_SYNC  out  vertical sync (active level V_POL)
//    oVGA_DE      out  active-video flag
//    oVGA_BLANK   out  DAC blank_n, same as oVGA_DE
//    oVGA_SYNC    out  DAC sync-on-green, tied low
//    oVGA_CLOCK   out  pixel clock forwarded to the DAC
//    oX / oY      out  active column / row, zero outside active video
//    oFrameStart  out  one-clock pulse at the start of each frame
//    oLineStart   out  one-clock pulse at the start of each line
// ============================================================================
module vga_timing_gen_param #(
  parameter int COLOR_W  = 10,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int REQ_LEAD = 3,
  parameter int CHK_LOG2 = 5
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iEN,
  input  logic [1:0]         iPattern,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oRequest,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_DE,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK,
  output logic [11:0]        oX,
  output logic [11:0]        oY,
  output logic               oFrameStart,
  output logic               oLineStart
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int BAR_W   = ((H_ACT / 8) > 1) ? (H_ACT / 8) : 1;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_END    = 12'(H_SYNC);
  localparam logic [11:0] VS_END    = 12'(V_SYNC);
  localparam logic [11:0] HA_START  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] HA_END    = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] VA_START  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] VA_END    = 12'(V_SYNC + V_BP + V_ACT);
  localparam logic [11:0] RQ_START  = 12'(H_SYNC + H_BP - REQ_LEAD);
  localparam logic [11:0] RQ_END    = 12'(H_SYNC + H_BP + H_ACT - REQ_LEAD);
  // Bar state is primed on the clock just before the first active column.
  localparam logic [11:0] BAR_PRIME = 12'(H_SYNC + H_BP - 1);
  localparam logic [11:0] BAR_LAST  = 12'(BAR_W - 1);

  localparam logic HS_ACTIVE = 1'(H_POL);
  localparam logic VS_ACTIVE = 1'(V_POL);

  localparam logic [COLOR_W-1:0] FS = '1;

  // Raster counters
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  // Frame-synchronous pattern mode
  logic [1:0] mode;

  // Running colour-bar state for the pixel at the current h_cnt
  logic [11:0] bar_pos;
  logic [2:0]  bar_idx;

  // Registered outputs
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               req;
  logic [11:0]        x_pos;
  logic [11:0]        y_pos;
  logic               frame_pulse;
  logic               line_pulse;
  logic [COLOR_W-1:0] pat_red;
  logic [COLOR_W-1:0] pat_green;
  logic [COLOR_W-1:0] pat_blue;

  // Decode of the current counter position
  logic        h_act;
  logic        v_act;
  logic        act;
  logic        req_win;
  logic        at_origin;
  logic [11:0] x_cur;
  logic [11:0] y_cur;

  assign h_act     = (h_cnt >= HA_START) && (h_cnt < HA_END);
  assign v_act     = (v_cnt >= VA_START) && (v_cnt < VA_END);
  assign act       = h_act && v_act;
  assign req_win   = (h_cnt >= RQ_START) && (h_cnt < RQ_END) && v_act;
  assign at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign x_cur     = h_cnt - HA_START;
  assign y_cur     = v_cnt - VA_START;

  // Pattern colour for the pixel at the current counters
  logic [2:0]         bar_rgb;
  logic [COLOR_W-1:0] nxt_red;
  logic [COLOR_W-1:0] nxt_green;
  logic [COLOR_W-1:0] nxt_blue;

  always_comb begin
    bar_rgb = 3'b000;
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;  // white
      3'd1:    bar_rgb = 3'b110;  // yellow
      3'd2:    bar_rgb = 3'b011;  // cyan
      3'd3:    bar_rgb = 3'b010;  // green
      3'd4:    bar_rgb = 3'b101;  // magenta
      3'd5:    bar_rgb = 3'b100;  // red
      3'd6:    bar_rgb = 3'b001;  // blue
      default: bar_rgb = 3'b000;  // black
    endcase
  end

  always_comb begin
    nxt_red   = '0;
    nxt_green = '0;
    nxt_blue  = '0;
    if (act) begin
      case (mode)
        2'd1: begin
          nxt_red   = bar_rgb[2] ? FS : '0;
          nxt_green = bar_rgb[1] ? FS : '0;
          nxt_blue  = bar_rgb[0] ? FS : '0;
        end
        2'd2: begin
          if (x_cur[CHK_LOG2] ^ y_cur[CHK_LOG2]) begin
            nxt_red   = FS;
            nxt_green = FS;
            nxt_blue  = FS;
          end
        end
        2'd3: begin
          nxt_red   = FS;
          nxt_green = FS;
          nxt_blue  = FS;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_cnt       <= 12'd0;
      v_cnt       <= 12'd0;
      mode        <= 2'd0;
      bar_pos     <= 12'd0;
      bar_idx     <= 3'd0;
      hsync       <= ~HS_ACTIVE;
      vsync       <= ~VS_ACTIVE;
      de          <= 1'b0;
      req         <= 1'b0;
      x_pos       <= 12'd0;
      y_pos       <= 12'd0;
      frame_pulse <= 1'b0;
      line_pulse  <= 1'b0;
      pat_red     <= '0;
      pat_green   <= '0;
      pat_blue    <= '0;
    end else if (!iEN) begin
      // Idle: park at the origin so the first enabled clock starts a frame.
      h_cnt       <= 12'd0;
      v_cnt       <= 12'd0;
      bar_pos     <= 12'd0;
      bar_idx     <= 3'd0;
      hsync       <= ~HS_ACTIVE;
      vsync       <= ~VS_ACTIVE;
      de          <= 1'b0;
      req         <= 1'b0;
      x_pos       <= 12'd0;
      y_pos       <= 12'd0;
      frame_pulse <= 1'b0;
      line_pulse  <= 1'b0;
      pat_red     <= '0;
      pat_green   <= '0;
      pat_blue    <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 12'd0;
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end

      if (at_origin) begin
        mode <= iPattern;
      end

      // Bar index advances every BAR_W active pixels and saturates at the
      // last bar, so columns beyond 8*BAR_W stay black without a divider.
      if (h_cnt == BAR_PRIME) begin
        bar_pos <= 12'd0;
        bar_idx <= 3'd0;
      end else if (h_act) begin
        if (bar_pos == BAR_LAST) begin
          bar_pos <= 12'd0;
          if (bar_idx != 3'd7) begin
            bar_idx <= bar_idx + 3'd1;
          end
        end else begin
          bar_pos <= bar_pos + 12'd1;
        end
      end

      hsync       <= (h_cnt < HS_END) ? HS_ACTIVE : ~HS_ACTIVE;
      vsync       <= (v_cnt < VS_END) ? VS_ACTIVE : ~VS_ACTIVE;
      de          <= act;
      req         <= req_win;
      x_pos       <= act ? x_cur : 12'd0;
      y_pos       <= act ? y_cur : 12'd0;
      frame_pulse <= at_origin;
      line_pulse  <= (h_cnt == 12'd0);
      pat_red     <= nxt_red;
      pat_green   <= nxt_green;
      pat_blue    <= nxt_blue;
    end
  end

  // Mode 0 forwards host colour combinationally; the host has already been
  // given REQ_LEAD clocks of lead through oRequest.
  assign oVGA_R = !de ? '0 : ((mode == 2'd0) ? iRed   : pat_red);
  assign oVGA_G = !de ? '0 : ((mode == 2'd0) ? iGreen : pat_green);
  assign oVGA_B = !de ? '0 : ((mode == 2'd0) ? iBlue  : pat_blue);

  assign oRequest    = req;
  assign oVGA_H_SYNC = hsync;
  assign oVGA_V_SYNC = vsync;
  assign oVGA_DE     = de;
  assign oVGA_BLANK  = de;
  assign oVGA_SYNC   = 1'b0;
  assign oVGA_CLOCK  = iCLK;
  assign oX          = x_pos;
  assign oY          = y_pos;
  assign oFrameStart = frame_pulse;
  assign oLineStart  = line_pulse;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen_param
//  Purpose  : Self-checking bench for vga_timing_gen_param using a small
//             16x8 raster. Expected active pixels are queued by the stimulus
//             process and consumed by a monitor whenever oVGA_DE is high;
//             sync, request and pulse timing is checked clock by clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen_param;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [9:0]  r;
    logic [9:0]  g;
    logic [9:0]  b;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pattern;
  logic [9:0]  red, green, blue;

  logic        req, hs, vs, de, blank, sog, vclk, fs, ls;
  logic [9:0]  r, g, b;
  logic [11:0] x, y;

  logic        req2, hs2, vs2, de2, blank2, sog2, vclk2, fs2, ls2;
  logic [9:0]  r2, g2, b2;
  logic [11:0] x2, y2;

  int n_cmp = 0;
  int n_err = 0;
  pix_t exp_q[$];

  // Hand-derived per-column tables (bit index = column)
  logic [7:0] bar_r_tab = 8'b00110011;
  logic [7:0] bar_g_tab = 8'b00001111;
  logic [7:0] bar_b_tab = 8'b01010101;
  logic [7:0] chk_row0  = 8'b11001100;

  always #5 clk = ~clk;

  vga_timing_gen_param #(
    .COLOR_W(10), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .REQ_LEAD(2), .CHK_LOG2(1)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iPattern(pattern),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oRequest(req), .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
    .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_DE(de), .oVGA_BLANK(blank),
    .oVGA_SYNC(sog), .oVGA_CLOCK(vclk), .oX(x), .oY(y),
    .oFrameStart(fs), .oLineStart(ls)
  );

  vga_timing_gen_param #(
    .COLOR_W(10), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .REQ_LEAD(2), .CHK_LOG2(1)
  ) dut_pol (
    .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iPattern(pattern),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oRequest(req2), .oVGA_R(r2), .oVGA_G(g2), .oVGA_B(b2),
    .oVGA_H_SYNC(hs2), .oVGA_V_SYNC(vs2), .oVGA_DE(de2), .oVGA_BLANK(blank2),
    .oVGA_SYNC(sog2), .oVGA_CLOCK(vclk2), .oX(x2), .oY(y2),
    .oFrameStart(fs2), .oLineStart(ls2)
  );

  task automatic chk(input string name, input int tag,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic push_pix(input int px, input int py, input int mode);
    pix_t p;
    logic on;
    p.x = 12'(px);
    p.y = 12'(py);
    case (mode)
      0: begin p.r = 10'h155; p.g = 10'h0AA; p.b = 10'h3FF; end
      1: begin
        p.r = bar_r_tab[px] ? 10'h3FF : 10'h000;
        p.g = bar_g_tab[px] ? 10'h3FF : 10'h000;
        p.b = bar_b_tab[px] ? 10'h3FF : 10'h000;
      end
      2: begin
        on  = (py < 2) ? chk_row0[px] : ~chk_row0[px];
        p.r = on ? 10'h3FF : 10'h000;
        p.g = p.r;
        p.b = p.r;
      end
      default: begin p.r = 10'h3FF; p.g = 10'h3FF; p.b = 10'h3FF; end
    endcase
    exp_q.push_back(p);
  endtask

  task automatic push_frame(input int mode);
    for (int py = 0; py < 4; py++)
      for (int px = 0; px < 8; px++)
        push_pix(px, py, mode);
  endtask

  // Frame cut short at oX=3 of the second active row.
  task automatic push_partial(input int mode);
    for (int px = 0; px < 8; px++) push_pix(px, 0, mode);
    for (int px = 0; px < 4; px++) push_pix(px, 1, mode);
  endtask

  // Monitor: consume one expected pixel per DE clock, blank elsewhere.
  int mon_t = 0;
  always @(negedge clk) begin
    pix_t e;
    mon_t++;
    chk("blank_vs_de", mon_t, blank, de);
    chk("sog_zero", mon_t, sog, 1'b0);
    if (de === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pixel @%0d: got x=%0d y=%0d expected no pixel", mon_t, x, y);
      end else begin
        e = exp_q.pop_front();
        chk("pix_x", mon_t, x, e.x);
        chk("pix_y", mon_t, y, e.y);
        chk("pix_r", mon_t, r, e.r);
        chk("pix_g", mon_t, g, e.g);
        chk("pix_b", mon_t, b, e.b);
      end
    end else begin
      chk("blank_rgb", mon_t, {r, g, b}, 30'd0);
      chk("blank_xy", mon_t, {x, y}, 24'd0);
    end
  end

  task automatic chk_idle(input string name, input int tag);
    chk({name, "_hs"}, tag, hs, 1'b1);
    chk({name, "_vs"}, tag, vs, 1'b1);
    chk({name, "_hs_pol"}, tag, hs2, 1'b0);
    chk({name, "_de"}, tag, de, 1'b0);
    chk({name, "_req"}, tag, req, 1'b0);
    chk({name, "_pulses"}, tag, {fs, ls}, 2'b00);
    chk({name, "_xy"}, tag, {x, y}, 24'd0);
    chk({name, "_rgb"}, tag, {r, g, b}, 30'd0);
  endtask

  initial begin
    int t, h, ln;
    rst_n   = 1'b0;
    en      = 1'b1;
    pattern = 2'd0;
    red     = 10'h155;
    green   = 10'h0AA;
    blue    = 10'h3FF;
    repeat (3) @(negedge clk);
    chk_idle("reset", 0);
    chk("reset_vs_pol", 0, vs2, 1'b0);

    push_frame(0);     // frame 0: pass-through
    push_frame(1);     // frame 1: bars (switch to white requested mid-frame)
    push_frame(3);     // frame 2: solid white
    push_frame(2);     // frame 3: checkerboard
    push_partial(2);   // frame 4: cut by iEN
    push_partial(2);   // frame 5: cut by reset

    rst_n = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      t  = k - 1;
      h  = t % 16;
      ln = (t / 16) % 8;
      chk("hsync", k, hs, (h < 3) ? 1'b0 : 1'b1);
      chk("vsync", k, vs, (ln < 2) ? 1'b0 : 1'b1);
      chk("hsync_pol", k, hs2, (h < 3) ? 1'b1 : 1'b0);
      chk("vsync_pol", k, vs2, (ln < 2) ? 1'b1 : 1'b0);
      chk("request", k, req, (ln >= 3 && ln <= 6 && h >= 4 && h <= 11) ? 1'b1 : 1'b0);
      chk("de", k, de, (ln >= 3 && ln <= 6 && h >= 6 && h <= 13) ? 1'b1 : 1'b0);
      chk("frame_start", k, fs, (t % 128 == 0) ? 1'b1 : 1'b0);
      chk("line_start", k, ls, (h == 0) ? 1'b1 : 1'b0);
      if (k == 20)  pattern = 2'd1;
      if (k == 200) pattern = 2'd3;
      if (k == 300) pattern = 2'd2;
    end

    // Frame 4: drop iEN at oX=3 of the second active row.
    repeat (74) @(negedge clk);
    chk("pre_en_drop_de", 586, de, 1'b1);
    chk("pre_en_drop_xy", 586, {x, y}, {12'd3, 12'd1});
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle("en_low", 587 + i);
    end
    en = 1'b1;
    @(negedge clk);
    chk("en_rise_fs", 607, fs, 1'b1);
    chk("en_rise_ls", 607, ls, 1'b1);
    chk("en_rise_hs", 607, hs, 1'b0);
    chk("en_rise_de", 607, de, 1'b0);

    // Frame 5: assert reset mid-line, between clock edges.
    repeat (73) @(negedge clk);
    chk("pre_rst_de", 680, de, 1'b1);
    chk("pre_rst_xy", 680, {x, y}, {12'd3, 12'd1});
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst", 680);
    chk("async_rst_vs_pol", 680, vs2, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_fs", 683, fs, 1'b1);
    chk("rst_rel_hs", 683, hs, 1'b0);
    chk("rst_rel_vs", 683, vs, 1'b0);
    repeat (10) @(negedge clk);

    chk("leftover_pixels", 0, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
